regfile_sb: RTL and testbench

- Parametrised successor to the core integer register file.
- Generalised data width, register count and optional hard-wired zero register.
- Adds rising-edge writes, optional write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a sequential post-reset clear sweep.
- Sits between decode (read pointers, alloc) and writeback (write port).

---
 rtl/regfile_sb.sv | 137 +++++++++++++
 tb/tb_regfile_sb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register
// pending-write scoreboard, optional write-to-read bypass and a sequential
// clear sweep that zeroes every register after reset release.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            busy_o,
    input  logic [AW-1:0]   rs1_ptr_i,
    input  logic [AW-1:0]   rs2_ptr_i,
    output logic [XLEN-1:0] rs1_o,
    output logic [XLEN-1:0] rs2_o,
    output logic            rs1_pend_o,
    output logic            rs2_pend_o,
    input  logic            alloc_en_i,
    input  logic [AW-1:0]   alloc_ptr_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_ptr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    localparam logic [AW:0]   NREGS_C = (AW + 1)'(NREGS);
    localparam logic [AW-1:0] LAST_C  = AW'(NREGS - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     cnt_q;
    logic              busy_q;
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic              wr_fire;
    logic              alloc_fire;
    logic [AW-1:0]     rd_ptr  [2];
    logic [XLEN-1:0]   rd_data [2];
    logic [1:0]        rd_pend;

    // A pointer addresses real storage: in range and not the hard-wired zero register.
    function automatic logic ptr_ok(input logic [AW-1:0] p);
        return ({1'b0, p} < NREGS_C) && !((ZERO_REG != 0) && (p == '0));
    endfunction

    assign wr_fire    = (state_q == S_RUN) && wr_en_i    && ptr_ok(wr_ptr_i);
    assign alloc_fire = (state_q == S_RUN) && alloc_en_i && ptr_ok(alloc_ptr_i);

    // Sweep controller: walk cnt over every register once, then enter RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (cnt_q == LAST_C) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    // Scoreboard next state: writeback retires a producer, alloc applied last so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_fire) begin
            pend_d[wr_ptr_i] = 1'b0;
        end
        if (alloc_fire) begin
            pend_d[alloc_ptr_i] = 1'b1;
        end
    end

    // Scoreboard register; cleared by reset so INIT starts with nothing outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Storage has no reset; the sweep zeroes it, writeback updates it in RUN.
    always_ff @(posedge clk_i) begin
        if (state_q == S_INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_ptr[0] = rs1_ptr_i;
    assign rd_ptr[1] = rs2_ptr_i;

    // Read ports: zero while sweeping or for unmapped/zero pointers, else bypass or storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_pend[p] = 1'b0;
            if ((state_q == S_RUN) && ptr_ok(rd_ptr[p])) begin
                if ((BYPASS != 0) && wr_fire && (wr_ptr_i == rd_ptr[p])) begin
                    rd_data[p] = wr_data_i;
                end else begin
                    rd_data[p] = mem_q[rd_ptr[p]];
                    rd_pend[p] = pend_q[rd_ptr[p]];
                end
            end
        end
    end

    assign rs1_o      = rd_data[0];
    assign rs2_o      = rd_data[1];
    assign rs1_pend_o = rd_pend[0];
    assign rs2_pend_o = rd_pend[1];
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: three regfile_sb configurations (32/bypass, 32/no bypass,
// 24/bypass) driven from one stimulus stream and compared each cycle against
// a behavioural model of the register file, scoreboard and clear sweep.
module tb_regfile_sb;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_ptr, rs2_ptr, alloc_ptr, wr_ptr;
    logic        alloc_en, wr_en;
    logic [31:0] wr_data;

    logic [31:0] rs1_w  [ND];
    logic [31:0] rs2_w  [ND];
    logic        rs1p_w [ND];
    logic        rs2p_w [ND];
    logic        busy_w [ND];

    int n_checks = 0;
    int n_errs   = 0;

    // behavioural model state
    logic [31:0] m_reg  [ND][32];
    bit          m_pend [ND][32];
    bit          m_init [ND];
    int          m_cnt  [ND];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_w[0]),
        .rs1_ptr_i(rs1_ptr), .rs2_ptr_i(rs2_ptr),
        .rs1_o(rs1_w[0]), .rs2_o(rs2_w[0]),
        .rs1_pend_o(rs1p_w[0]), .rs2_pend_o(rs2p_w[0]),
        .alloc_en_i(alloc_en), .alloc_ptr_i(alloc_ptr),
        .wr_en_i(wr_en), .wr_ptr_i(wr_ptr), .wr_data_i(wr_data)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_w[1]),
        .rs1_ptr_i(rs1_ptr), .rs2_ptr_i(rs2_ptr),
        .rs1_o(rs1_w[1]), .rs2_o(rs2_w[1]),
        .rs1_pend_o(rs1p_w[1]), .rs2_pend_o(rs2p_w[1]),
        .alloc_en_i(alloc_en), .alloc_ptr_i(alloc_ptr),
        .wr_en_i(wr_en), .wr_ptr_i(wr_ptr), .wr_data_i(wr_data)
    );

    regfile_sb #(.XLEN(32), .NREGS(24), .ZERO_REG(1), .BYPASS(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_w[2]),
        .rs1_ptr_i(rs1_ptr), .rs2_ptr_i(rs2_ptr),
        .rs1_o(rs1_w[2]), .rs2_o(rs2_w[2]),
        .rs1_pend_o(rs1p_w[2]), .rs2_pend_o(rs2p_w[2]),
        .alloc_en_i(alloc_en), .alloc_ptr_i(alloc_ptr),
        .wr_en_i(wr_en), .wr_ptr_i(wr_ptr), .wr_data_i(wr_data)
    );

    function automatic int nr(input int d);
        return (d == 2) ? 24 : 32;
    endfunction

    function automatic bit byp(input int d);
        return d != 1;
    endfunction

    function automatic bit addr_ok(input int d, input logic [4:0] p);
        return (int'(p) < nr(d)) && (p != 5'd0);
    endfunction

    function automatic void model_read(input int d, input logic [4:0] p,
                                       output logic [31:0] data, output bit pend);
        data = '0;
        pend = 1'b0;
        if (!m_init[d] && addr_ok(d, p)) begin
            if (byp(d) && wr_en && addr_ok(d, wr_ptr) && (wr_ptr == p)) begin
                data = wr_data;
            end else begin
                data = m_reg[d][int'(p)];
                pend = m_pend[d][int'(p)];
            end
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_init[d] = 1'b1;
            m_cnt[d]  = 0;
            for (int r = 0; r < 32; r++) m_pend[d][r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_init[d] = 1'b1;
                m_cnt[d]  = 0;
                for (int r = 0; r < 32; r++) m_pend[d][r] = 1'b0;
            end else if (m_init[d]) begin
                m_reg[d][m_cnt[d]] = '0;
                m_cnt[d]++;
                if (m_cnt[d] == nr(d)) m_init[d] = 1'b0;
            end else begin
                if (wr_en && addr_ok(d, wr_ptr)) begin
                    m_reg[d][int'(wr_ptr)]  = wr_data;
                    m_pend[d][int'(wr_ptr)] = 1'b0;
                end
                if (alloc_en && addr_ok(d, alloc_ptr)) m_pend[d][int'(alloc_ptr)] = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] d1, d2;
        bit          p1, p2;
        for (int d = 0; d < ND; d++) begin
            model_read(d, rs1_ptr, d1, p1);
            model_read(d, rs2_ptr, d2, p2);
            check($sformatf("d%0d rs1", d),  rs1_w[d], d1);
            check($sformatf("d%0d rs2", d),  rs2_w[d], d2);
            check($sformatf("d%0d pend1", d), 32'(rs1p_w[d]), 32'(p1));
            check($sformatf("d%0d pend2", d), 32'(rs2p_w[d]), 32'(p2));
            check($sformatf("d%0d busy", d),  32'(busy_w[d]), 32'(m_init[d]));
        end
    endtask

    // inputs are driven just after the falling edge; outputs sampled 2 time units later
    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        alloc_en = 1'b0;
    endtask

    task automatic set_rst(input bit v);
        rst = v;
        if (v) model_reset();
    endtask

    task automatic rand_inputs();
        bit narrow;
        narrow    = ($urandom_range(0, 1) == 1);
        rs1_ptr   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        rs2_ptr   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_ptr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        alloc_ptr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_en     = 1'($urandom_range(0, 1));
        alloc_en  = 1'($urandom_range(0, 1));
        wr_data   = $urandom;
    endtask

    task automatic run_sweep(input string tag);
        int n [ND];
        for (int d = 0; d < ND; d++) n[d] = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_init[0] || m_init[1] || m_init[2]) rand_inputs();
            else idle();
            settle();
            for (int d = 0; d < ND; d++) if (busy_w[d] === 1'b1) n[d]++;
            tick();
        end
        for (int d = 0; d < ND; d++)
            check($sformatf("%s busy_len d%0d", tag, d), 32'(n[d]), 32'(nr(d)));
    endtask

    initial begin
        rst = 1'b1;
        rs1_ptr = '0; rs2_ptr = '0; alloc_ptr = '0; wr_ptr = '0; wr_data = '0;
        idle();
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        set_rst(1'b0);
        run_sweep("sweep0");

        // pre-reset contents must be wiped by the next sweep
        wr_en = 1'b1; wr_ptr = 5'd5; wr_data = 32'hDEADBEEF;
        cycle();
        idle();
        rs1_ptr = 5'd5;
        settle();
        check("x5_written", rs1_w[0], 32'hDEADBEEF);
        tick();
        set_rst(1'b1);
        cycle();
        set_rst(1'b0);
        run_sweep("sweep1");
        rs1_ptr = 5'd5;
        settle();
        check("x5_cleared", rs1_w[0], 32'h0);
        tick();

        // zero register ignores write and alloc
        wr_en = 1'b1; wr_ptr = 5'd0; wr_data = 32'h1234;
        alloc_en = 1'b1; alloc_ptr = 5'd0; rs1_ptr = 5'd0;
        cycle();
        idle();
        settle();
        check("x0_data", rs1_w[0], 32'h0);
        check("x0_pend", 32'(rs1p_w[0]), 32'h0);
        tick();
        wr_en = 1'b1; wr_ptr = 5'd7; wr_data = 32'h1234;
        cycle();
        idle();
        rs2_ptr = 5'd7;
        settle();
        check("x7_data", rs2_w[0], 32'h00001234);
        tick();

        // same-cycle write forwarding vs. no bypass
        wr_en = 1'b1; wr_ptr = 5'd9; wr_data = 32'hA5A5A5A5; rs1_ptr = 5'd9;
        settle();
        check("byp_on_data", rs1_w[0], 32'hA5A5A5A5);
        check("byp_on_pend", 32'(rs1p_w[0]), 32'h0);
        check("byp_off_data", rs1_w[1], 32'h0);
        tick();
        idle();

        // scoreboard timing on x3
        alloc_en = 1'b1; alloc_ptr = 5'd3; rs1_ptr = 5'd3;
        settle();
        check("alloc_same_cycle", 32'(rs1p_w[0]), 32'h0);
        tick();
        idle();
        settle();
        check("alloc_t1", 32'(rs1p_w[0]), 32'h1);
        tick();
        cycle();
        cycle();
        wr_en = 1'b1; wr_ptr = 5'd3; wr_data = 32'h77;
        settle();
        check("wb_t4_byp_pend", 32'(rs1p_w[0]), 32'h0);
        check("wb_t4_nobyp_pend", 32'(rs1p_w[1]), 32'h1);
        tick();
        idle();
        settle();
        check("wb_t5_pend", 32'(rs1p_w[0]), 32'h0);
        check("wb_t5_nobyp_pend", 32'(rs1p_w[1]), 32'h0);
        tick();
        wr_en = 1'b1; wr_ptr = 5'd3; wr_data = 32'h88;
        alloc_en = 1'b1; alloc_ptr = 5'd3;
        cycle();
        idle();
        settle();
        check("alloc_wr_pend", 32'(rs1p_w[0]), 32'h1);
        check("alloc_wr_data", rs1_w[0], 32'h88);
        tick();

        // out-of-range pointer on the 24-entry instance
        wr_en = 1'b1; wr_ptr = 5'd30; wr_data = 32'hFFFF0000;
        alloc_en = 1'b1; alloc_ptr = 5'd30; rs1_ptr = 5'd30;
        settle();
        check("oor_data_now", rs1_w[2], 32'h0);
        check("oor_pend_now", 32'(rs1p_w[2]), 32'h0);
        tick();
        idle();
        settle();
        check("oor_data_next", rs1_w[2], 32'h0);
        check("oor_pend_next", 32'(rs1p_w[2]), 32'h0);
        tick();

        // reset in the middle of the sweep restarts it
        set_rst(1'b1);
        cycle();
        set_rst(1'b0);
        for (int c = 0; c < 10; c++) begin
            rand_inputs();
            cycle();
        end
        set_rst(1'b1);
        cycle();
        set_rst(1'b0);
        run_sweep("sweep_mid");

        // randomized traffic with occasional reset
        for (int c = 0; c < 2000; c++) begin
            rand_inputs();
            if ($urandom_range(0, 299) == 0) begin
                set_rst(1'b1);
                cycle();
                set_rst(1'b0);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
